hex_value_printer: RTL and testbench

- Parametrised successor to the team's fixed-format UART message printer.
- On a trigger edge it latches a DATA_WIDTH-bit value, then streams three parts to the UART transmitter via the tx_data/new_tx_data/tx_busy handshake:
  - a PREFIX string parameter;
  - the value as uppercase hex ASCII, MS nibble first;
  - a SUFFIX string parameter.
- Sits between debug/test logic and the existing uart_tx.

---
 rtl/hex_value_printer_pkg.sv | 23 ++
 rtl/hex_value_printer_if.sv | 12 +
 rtl/hex_value_printer_nibble_to_ascii.sv | 15 +
 rtl/hex_value_printer.sv | 187 ++++++++++++++++++
 tb/tb_hex_value_printer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_value_printer_pkg.sv
// Shared types and constants for the hex value printer.
package hex_printer_pkg;

  // FSM state encoding; exposed on the debug port of hex_value_printer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_DATA   = 2'd2,
    ST_SUFFIX = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;

  // Ceiling log2, used to size the character index counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/hex_value_printer_if.sv
// Byte handshake towards the existing uart_tx.
// Handshake: the printer pulses new_tx_data for exactly one cycle with tx_data
// valid in that cycle; it never pulses while tx_busy is high, and never in two
// consecutive cycles, so the UART always has one cycle to raise tx_busy.
interface hex_value_printer_if;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;

  modport master (output tx_data, output new_tx_data, input tx_busy);
  modport slave  (input tx_data, input new_tx_data, output tx_busy);
endinterface

// File: rtl/hex_value_printer_nibble_to_ascii.sv
// Maps one hex nibble to its uppercase ASCII character.
module nibble_to_ascii
  import hex_printer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0..9 map onto '0'..'9', 10..15 onto 'A'..'F'.
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'b0000, nibble};
    else                ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
  end

endmodule

// File: rtl/hex_value_printer.sv
// Prints PREFIX, a latched value as uppercase hex, then SUFFIX to the UART.
// Optional macro HEX_PRINTER_ZERO_SUPPRESS_EN: skip leading zero digits
// (the least significant digit is always printed).
module hex_value_printer
  import hex_printer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PREFIX_LEN = 8,
  parameter logic [8*((PREFIX_LEN > 0) ? PREFIX_LEN : 1)-1:0] PREFIX = "Value = ",
  parameter int SUFFIX_LEN = 2,
  parameter logic [8*((SUFFIX_LEN > 0) ? SUFFIX_LEN : 1)-1:0] SUFFIX = "\r\n"
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] value,
  hex_value_printer_if.master   tx_if,
  output logic                  busy,
  output logic                  done,
  output state_t                dbg_state
);

  localparam int NDIG  = DATA_WIDTH / 4;
  localparam int PA    = (PREFIX_LEN > 0) ? PREFIX_LEN : 1;
  localparam int SA    = (SUFFIX_LEN > 0) ? SUFFIX_LEN : 1;
  localparam int MAXC  = (PA > NDIG) ? ((PA > SA) ? PA : SA) : ((NDIG > SA) ? NDIG : SA);
  localparam int IDX_W = (clog2(MAXC) > 0) ? clog2(MAXC) : 1;
  localparam logic [IDX_W-1:0] P_LAST = IDX_W'(PA - 1);
  localparam logic [IDX_W-1:0] D_LAST = IDX_W'(NDIG - 1);
  localparam logic [IDX_W-1:0] S_LAST = IDX_W'(SA - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  trig_q, trig_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  new_tx_q, new_tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic       trig_edge;
  logic       can_issue;
  logic       skip;
  logic [7:0] prefix_char;
  logic [7:0] suffix_char;
  logic [3:0] digit;
  logic [7:0] digit_ascii;

  assign trig_edge = trigger & ~trig_q;
  // A strobe never follows a strobe, so the UART gets a cycle to raise tx_busy.
  assign can_issue = ~tx_if.tx_busy & ~new_tx_q;

  // Select the prefix, suffix and digit addressed by the index counter.
  always_comb begin
    prefix_char = '0;
    suffix_char = '0;
    digit       = '0;
    for (int i = 0; i < PA; i++)
      if (idx_q == IDX_W'(i)) prefix_char = PREFIX[8*(PA-1-i) +: 8];
    for (int i = 0; i < SA; i++)
      if (idx_q == IDX_W'(i)) suffix_char = SUFFIX[8*(SA-1-i) +: 8];
    for (int i = 0; i < NDIG; i++)
      if (idx_q == IDX_W'(i)) digit = value_q[DATA_WIDTH-1-4*i -: 4];
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nibble (digit),
    .ascii  (digit_ascii)
  );

`ifdef HEX_PRINTER_ZERO_SUPPRESS_EN
  logic started_q, started_d;
  assign skip = (state_q == ST_DATA) && !started_q && (digit == 4'd0) && (idx_q != D_LAST);
`else
  assign skip = 1'b0;
`endif

  // Next-state logic: accept edges in IDLE, issue one byte per permitted cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    value_d   = value_q;
    trig_d    = trigger;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          value_d = value;
          busy_d  = 1'b1;
          idx_d   = '0;
          state_d = (PREFIX_LEN > 0) ? ST_PREFIX : ST_DATA;
        end
      end
      ST_PREFIX: begin
        if (can_issue) begin
          tx_data_d = prefix_char;
          new_tx_d  = 1'b1;
          if (idx_q == P_LAST) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (skip) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (can_issue) begin
          tx_data_d = digit_ascii;
          new_tx_d  = 1'b1;
          if (idx_q == D_LAST) begin
            idx_d = '0;
            if (SUFFIX_LEN > 0) begin
              state_d = ST_SUFFIX;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_SUFFIX: begin
        if (can_issue) begin
          tx_data_d = suffix_char;
          new_tx_d  = 1'b1;
          if (idx_q == S_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef HEX_PRINTER_ZERO_SUPPRESS_EN
    started_d = started_q;
    if (new_tx_d && (state_q == ST_DATA)) started_d = 1'b1;
    if (state_d != ST_DATA)               started_d = 1'b0;
`endif
  end

  // State and registered outputs; reset abandons any message in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      value_q   <= '0;
      trig_q    <= 1'b0;
      tx_data_q <= '0;
      new_tx_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef HEX_PRINTER_ZERO_SUPPRESS_EN
      started_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      trig_q    <= trig_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef HEX_PRINTER_ZERO_SUPPRESS_EN
      started_q <= started_d;
`endif
    end
  end

  assign tx_if.tx_data     = tx_data_q;
  assign tx_if.new_tx_data = new_tx_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_hex_value_printer.sv
// Bench for hex_value_printer: a default instance and an 8-bit instance
// without prefix/suffix, checked against a string-level message model.
module tb_hex_value_printer;
  import hex_printer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        trig_a = 1'b0;
  logic        trig_b = 1'b0;
  logic [15:0] val_a  = '0;
  logic [7:0]  val_b  = '0;
  logic        busy_a, done_a, busy_b, done_b;
  state_t      st_a, st_b;

  hex_value_printer_if ia ();
  hex_value_printer_if ib ();

  hex_value_printer dut_a (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig_a),
    .value     (val_a),
    .tx_if     (ia.master),
    .busy      (busy_a),
    .done      (done_a),
    .dbg_state (st_a)
  );

  hex_value_printer #(
    .DATA_WIDTH (8),
    .PREFIX_LEN (0),
    .PREFIX     (8'h00),
    .SUFFIX_LEN (0),
    .SUFFIX     (8'h00)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig_b),
    .value     (val_b),
    .tx_if     (ib.master),
    .busy      (busy_b),
    .done      (done_b),
    .dbg_state (st_b)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];

  function automatic string hex_str(input logic [31:0] v, input int ndig);
    string s;
    s = $sformatf("%0h", v);
    s = s.toupper();
`ifndef HEX_PRINTER_ZERO_SUPPRESS_EN
    while (s.len() < ndig) s = {"0", s};
`endif
    return s;
  endfunction

  function automatic int push_a(input logic [15:0] v);
    string m;
    m = {"Value = ", hex_str(32'(v), 4), "\r\n"};
    for (int i = 0; i < m.len(); i++) exp_a_q.push_back(m[i]);
    return m.len();
  endfunction

  function automatic int push_b(input logic [7:0] v);
    string m;
    m = hex_str(32'(v), 2);
    for (int i = 0; i < m.len(); i++) exp_b_q.push_back(m[i]);
    return m.len();
  endfunction

  // ---------------- monitor + UART busy model ----------------
  int   strobes_a = 0, strobes_b = 0, msg_a = 0, msg_b = 0;
  int   dones_a = 0, dones_b = 0, cnt_a = 0, busy_len = 10;
  int   trig_cyc_a = 0, last_cyc_a = 0;
  bit   uart_a = 1'b0, timing_on = 1'b0;
  logic prev_new_a = 1'b0, prev_new_b = 1'b0;

  always @(negedge clk) begin
    if (ia.new_tx_data === 1'b1) begin
      if (exp_a_q.size() > 0) check_eq("a_byte", ia.tx_data, exp_a_q.pop_front());
      check_eq("a_gap", prev_new_a, 0);
      check_eq("a_tx_busy", ia.tx_busy, 0);
      check_eq("a_busy_vs_done", busy_a, !done_a);
      if (timing_on) begin
        if (msg_a == 0) check_eq("a_first_lat", cyc - trig_cyc_a, 2);
        else            check_eq("a_spacing", cyc - last_cyc_a, 2);
      end
      last_cyc_a = cyc;
      strobes_a++;
      msg_a++;
    end
    if (done_a === 1'b1) begin
      dones_a++;
      check_eq("a_done_with_strobe", ia.new_tx_data, 1);
    end
    if (ib.new_tx_data === 1'b1) begin
      if (exp_b_q.size() > 0) check_eq("b_byte", ib.tx_data, exp_b_q.pop_front());
      check_eq("b_gap", prev_new_b, 0);
      check_eq("b_busy_vs_done", busy_b, !done_b);
      strobes_b++;
      msg_b++;
    end
    if (done_b === 1'b1) dones_b++;
    prev_new_a = ia.new_tx_data;
    prev_new_b = ib.new_tx_data;
    if (uart_a && ia.new_tx_data === 1'b1) cnt_a = busy_len;
    else if (cnt_a > 0)                    cnt_a--;
    ia.tx_busy = (cnt_a > 0);
    ib.tx_busy = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_a(input logic [15:0] v);
    val_a      = v;
    trig_a     = 1'b1;
    trig_cyc_a = cyc;
    @(posedge clk); #1;
    trig_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done_a) seen = 1'b1;
    end
    check_eq("a_done_seen", seen, 1);
  endtask

  task automatic run_a(input logic [15:0] v);
    int n;
    msg_a = 0;
    n = push_a(v);
    pulse_a(v);
    wait_done_a(2000);
    @(negedge clk); #1;
    check_eq("a_msg_len", msg_a, n);
    check_eq("a_queue_empty", exp_a_q.size(), 0);
    check_eq("a_busy_after", busy_a, 0);
  endtask

  task automatic run_b(input logic [7:0] v);
    int  n;
    bit  seen;
    msg_b = 0;
    n = push_b(v);
    val_b  = v;
    trig_b = 1'b1;
    @(posedge clk); #1;
    trig_b = 1'b0;
    check_eq("b_busy_accept", busy_b, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_b) seen = 1'b1;
    end
    check_eq("b_done_seen", seen, 1);
    @(negedge clk); #1;
    check_eq("b_msg_len", msg_b, n);
    check_eq("b_queue_empty", exp_b_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n1, n2, s_save, d_save;
    bit seen;

    // Reset state
    idle_cycles(3);
    check_eq("rst_new_tx", ia.new_tx_data, 0);
    check_eq("rst_tx_data", ia.tx_data, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_state", st_a, ST_IDLE);
    check_eq("rst_b_busy", busy_b, 0);
    rst = 1'b0;
    idle_cycles(2);

    // Default message, tx_busy low: latency and strobe spacing
    timing_on = 1'b1;
    run_a(16'h1A2F);
    timing_on = 1'b0;

    // UART-like tx_busy, 10 cycles per byte
    uart_a = 1'b1; busy_len = 10;
    run_a(16'h1A2F);
    uart_a = 1'b0;
    idle_cycles(12);

    // Trigger held high with a re-pulse mid-message: exactly one message
    msg_a  = 0;
    d_save = dones_a;
    n1 = push_a(16'hBEEF);
    val_a  = 16'hBEEF;
    trig_a = 1'b1;
    idle_cycles(10);
    trig_a = 1'b0;
    idle_cycles(1);
    trig_a = 1'b1;
    val_a  = 16'h1234;
    idle_cycles(90);
    trig_a = 1'b0;
    idle_cycles(5);
    check_eq("hold_msg_len", msg_a, n1);
    check_eq("hold_one_done", dones_a - d_save, 1);
    check_eq("hold_queue_empty", exp_a_q.size(), 0);

    // Edge in the cycle after done starts a new message
    msg_a = 0;
    n1 = push_a(16'h00C3);
    pulse_a(16'h00C3);
    wait_done_a(500);
    n2 = push_a(16'h7E01);
    val_a  = 16'h7E01;
    trig_a = 1'b1;
    idle_cycles(1);
    trig_a = 1'b0;
    check_eq("rearm_busy", busy_a, 1);
    wait_done_a(500);
    @(negedge clk); #1;
    check_eq("rearm_msg_len", msg_a, n1 + n2);

    // Reset after the 5th strobe abandons the message
    msg_a = 0;
    void'(push_a(16'h5A5A));
    pulse_a(16'h5A5A);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (msg_a >= 5) seen = 1'b1;
    end
    check_eq("rst5_reached", seen, 1);
    rst = 1'b1;
    #1;
    check_eq("rst5_new_tx", ia.new_tx_data, 0);
    check_eq("rst5_busy", busy_a, 0);
    check_eq("rst5_done", done_a, 0);
    exp_a_q.delete();
    s_save = strobes_a;
    d_save = dones_a;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(20);
    check_eq("rst5_no_strobes", strobes_a - s_save, 0);
    check_eq("rst5_no_done", dones_a - d_save, 0);
    check_eq("rst5_state", st_a, ST_IDLE);
    run_a(16'h5A5A);

    // Narrow instance without prefix/suffix
    run_b(8'hF0);

    // Leading-zero values
    run_a(16'h000B);
    run_a(16'h0000);
    run_b(8'h00);

    // Randomised values and UART busy lengths
    for (int k = 0; k < 20; k++) begin
      uart_a   = ($urandom_range(0, 1) == 1);
      busy_len = $urandom_range(0, 12);
      run_a(16'($urandom));
      idle_cycles($urandom_range(0, 3));
      run_b(8'($urandom));
    end
    uart_a = 1'b0;
    idle_cycles(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
